// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencer: register index type, sequencer
// state and latch-vector bit positions.
package pipeline_ctrl_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  // Bit positions in the 4-wide latch control vectors.
  localparam int IFID  = 3;
  localparam int IDEX  = 2;
  localparam int EXMEM = 1;
  localparam int MEMWB = 0;

  // A latch that is flushed must not also report itself as advancing.
  function automatic logic [3:0] gate_en(input logic [3:0] en, input logic [3:0] flush);
    return en & ~flush;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch/PC control outputs of the pipeline sequencer.
// master = sequencer side, slave = datapath side.
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     exmem_dreq;
  logic     idex_dREN;
  regbits_t idex_wsel;
  regbits_t ifid_rs;
  regbits_t ifid_rt;
  logic     branch_ex;
  logic     jump_id;
  logic     halt_id;
  logic     halt_wb;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halt;
  logic     halt_timeout;

  modport master (
    input  ihit, dhit, exmem_dreq, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
           branch_ex, jump_id, halt_id, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, halt_timeout
  );

  modport slave (
    output ihit, dhit, exmem_dreq, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
           branch_ex, jump_id, halt_id, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, halt_timeout
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the
// instruction in ID reads ($zero never creates a dependency).
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     luse
);

  assign luse = idex_dREN && (idex_wsel != '0) &&
                ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: per-cycle advance/hold/bubble for PC and latches,
// halt drain with timeout. STALL_COUNTERS_EN adds stall/flush counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_MAX = 8
`ifdef STALL_COUNTERS_EN
  , parameter int CNT_W   = 32
`endif
) (
  input  logic CLK,
  input  logic RST,
  pipeline_ctrl_if.master pif
`ifdef STALL_COUNTERS_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam logic [DW-1:0] DMAX = DW'(DRAIN_MAX);

  pipe_state_t   state_q, state_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          halt_timeout_q, halt_timeout_d;

  logic          luse;
  logic          dstall;
  logic          pc_en;
  logic [3:0]    en;
  logic [3:0]    flush;
  logic [3:0]    en_out;

  hazard_detect u_hazard_detect (
    .idex_dREN (pif.idex_dREN),
    .idex_wsel (pif.idex_wsel),
    .ifid_rs   (pif.ifid_rs),
    .ifid_rt   (pif.ifid_rt),
    .luse      (luse)
  );

  assign dstall = pif.exmem_dreq & ~pif.dhit;

  always_comb begin
    pc_en          = 1'b1;
    en             = '1;
    flush          = '0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    halt_timeout_d = halt_timeout_q;

    unique case (state_q)
      RUN: begin
        if (dstall) begin
          pc_en        = 1'b0;
          en[IFID]     = 1'b0;
          en[IDEX]     = 1'b0;
          en[EXMEM]    = 1'b0;
          flush[MEMWB] = 1'b1;
        end else if (pif.branch_ex) begin
          flush[IFID]  = 1'b1;
          flush[IDEX]  = 1'b1;
        end else if (luse) begin
          pc_en        = 1'b0;
          en[IFID]     = 1'b0;
          flush[IDEX]  = 1'b1;
        end else if (pif.jump_id) begin
          flush[IFID]  = 1'b1;
        end else if (!pif.ihit) begin
          pc_en        = 1'b0;
          flush[IFID]  = 1'b1;
        end
        // A halt squashed by a branch, or held by a stall, is not yet committed.
        if (pif.halt_id && !dstall && !pif.branch_ex && !luse) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        pc_en       = 1'b0;
        flush[IFID] = 1'b1;
        if (dstall) begin
          en[IFID]     = 1'b0;
          en[IDEX]     = 1'b0;
          en[EXMEM]    = 1'b0;
          flush[MEMWB] = 1'b1;
        end else if (drain_cnt_q != DMAX) begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
        if (pif.halt_wb) begin
          state_d = HALTED;
        end else if (drain_cnt_d == DMAX) begin
          state_d        = HALTED;
          halt_timeout_d = 1'b1;
        end
      end
      HALTED: begin
        pc_en = 1'b0;
        en    = '0;
      end
      default: state_d = RUN;
    endcase
  end

  assign en_out = gate_en(en, flush);

  // Reset overrides every control output with a full bubble.
  assign pif.pc_en        = RST ? 1'b0 : pc_en;
  assign pif.ifid_en      = RST ? 1'b0 : en_out[IFID];
  assign pif.idex_en      = RST ? 1'b0 : en_out[IDEX];
  assign pif.exmem_en     = RST ? 1'b0 : en_out[EXMEM];
  assign pif.memwb_en     = RST ? 1'b0 : en_out[MEMWB];
  assign pif.ifid_flush   = RST | flush[IFID];
  assign pif.idex_flush   = RST | flush[IDEX];
  assign pif.exmem_flush  = RST | flush[EXMEM];
  assign pif.memwb_flush  = RST | flush[MEMWB];
  assign pif.halt         = (state_q == HALTED);
  assign pif.halt_timeout = halt_timeout_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= RUN;
      drain_cnt_q    <= '0;
      halt_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_cnt_q    <= drain_cnt_d;
      halt_timeout_q <= halt_timeout_d;
    end
  end

`ifdef STALL_COUNTERS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != HALTED) && !pc_en)
      stall_cnt_d = stall_cnt_q + 1'b1;
    if ((state_q == RUN) && (flush[IFID] || flush[IDEX]))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard/halt scenarios then random traffic,
// all against a cycle-level behavioural model (honours STALL_COUNTERS_EN).
module tb_pipeline_ctrl;

  localparam int DMAX = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if pif ();

`ifdef STALL_COUNTERS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  pipeline_ctrl #(
    .DRAIN_MAX (DMAX)
`ifdef STALL_COUNTERS_EN
    , .CNT_W   (32)
`endif
  ) dut (
    .CLK (clk),
    .RST (rst),
    .pif (pif)
`ifdef STALL_COUNTERS_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  logic [10:0] obs;
  assign obs = {pif.pc_en, pif.ifid_en, pif.idex_en, pif.exmem_en, pif.memwb_en,
                pif.ifid_flush, pif.idex_flush, pif.exmem_flush, pif.memwb_flush,
                pif.halt, pif.halt_timeout};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Model state: 0 running, 1 draining, 2 halted.
  int          m_state, n_state;
  int          m_cnt, n_cnt;
  bit          m_to, n_to;
  logic [31:0] m_stall, n_stall, m_flush, n_flush;

  task automatic model_eval(output logic [10:0] e);
    bit pc, mem_wait, lu;
    bit [3:0] en, fl;  // {ifid, idex, exmem, memwb}
    mem_wait = pif.exmem_dreq && !pif.dhit;
    lu = pif.idex_dREN && (pif.idex_wsel != 0) &&
         (pif.idex_wsel == pif.ifid_rs || pif.idex_wsel == pif.ifid_rt);
    n_state = m_state; n_cnt = m_cnt; n_to = m_to;
    n_stall = m_stall; n_flush = m_flush;
    pc = 1; en = 4'b1111; fl = 4'b0000;
    if (rst) begin
      pc = 0; en = 0; fl = 4'b1111;
      n_state = 0; n_cnt = 0; n_to = 0; n_stall = 0; n_flush = 0;
    end else if (m_state == 2) begin
      pc = 0; en = 0; fl = 0;
    end else begin
      if (m_state == 0) begin
        if (mem_wait)           begin pc = 0; en[3] = 0; en[2] = 0; en[1] = 0; fl[0] = 1; end
        else if (pif.branch_ex) begin fl[3] = 1; fl[2] = 1; end
        else if (lu)            begin pc = 0; en[3] = 0; fl[2] = 1; end
        else if (pif.jump_id)   begin fl[3] = 1; end
        else if (!pif.ihit)     begin pc = 0; fl[3] = 1; end
      end else begin
        pc = 0; fl[3] = 1;
        if (mem_wait) begin en[3] = 0; en[2] = 0; en[1] = 0; fl[0] = 1; end
      end
      en = en & ~fl;
      if (!pc) n_stall = m_stall + 1;
      if (m_state == 0 && (fl[3] || fl[2])) n_flush = m_flush + 1;
      if (m_state == 0) begin
        if (pif.halt_id && !mem_wait && !pif.branch_ex && !lu) begin
          n_state = 1; n_cnt = 0;
        end
      end else begin
        if (!mem_wait && m_cnt < DMAX) n_cnt = m_cnt + 1;
        if (pif.halt_wb) n_state = 2;
        else if (n_cnt >= DMAX) begin n_state = 2; n_to = 1; end
      end
    end
    e = {pc, en, fl, (m_state == 2), m_to};
  endtask

  task automatic tick(input string tag);
    logic [10:0] e;
    #1;
    model_eval(e);
    check(tag, 64'(obs), 64'(e));
`ifdef STALL_COUNTERS_EN
    check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(m_stall));
    check({tag, "_flush_cnt"}, 64'(flush_cnt), 64'(m_flush));
`endif
    @(posedge clk);
    m_state = n_state; m_cnt = n_cnt; m_to = n_to;
    m_stall = n_stall; m_flush = n_flush;
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst            = 1'b0;
    pif.ihit       = 1'b1;
    pif.dhit       = 1'b1;
    pif.exmem_dreq = 1'b0;
    pif.idex_dREN  = 1'b0;
    pif.idex_wsel  = '0;
    pif.ifid_rs    = '0;
    pif.ifid_rt    = '0;
    pif.branch_ex  = 1'b0;
    pif.jump_id    = 1'b0;
    pif.halt_id    = 1'b0;
    pif.halt_wb    = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    set_idle();
    rst = 1'b1;
    tick(tag);
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    m_state = 0; m_cnt = 0; m_to = 0; m_stall = 0; m_flush = 0;

    do_reset("reset");
    check("reset_halt", 64'(pif.halt), 64'd0);
    tick("idle");

    // Load-use: one bubble, then clean advance; $zero destination never stalls.
    set_idle(); pif.idex_dREN = 1; pif.idex_wsel = 5; pif.ifid_rs = 5;
    #1; check("luse_pc_en", 64'(pif.pc_en), 64'd0);
    check("luse_idex_flush", 64'(pif.idex_flush), 64'd1);
    tick("luse");
    set_idle(); tick("luse_after");
    pif.idex_dREN = 1; pif.idex_wsel = 0; pif.ifid_rs = 0;
    #1; check("luse_r0_pc_en", 64'(pif.pc_en), 64'd1);
    tick("luse_r0");

    // Data wait for three cycles, then hit.
    for (int i = 0; i < 4; i++) begin
      set_idle(); pif.exmem_dreq = 1; pif.dhit = (i == 3);
      #1; check("dwait_memwb_flush", 64'(pif.memwb_flush), (i == 3) ? 64'd0 : 64'd1);
      tick("dwait");
    end

    // Branch beats load-use.
    set_idle(); pif.branch_ex = 1; pif.idex_dREN = 1; pif.idex_wsel = 7; pif.ifid_rt = 7;
    #1; check("br_luse_pc_en", 64'(pif.pc_en), 64'd1);
    tick("br_luse");
    set_idle(); pif.jump_id = 1; tick("jump");
    set_idle(); pif.ihit = 0; tick("imiss");

    // Halt with halt_wb three cycles later.
    set_idle(); pif.halt_id = 1; tick("halt_enter");
    set_idle(); tick("drain1");
    tick("drain2");
    pif.halt_wb = 1; tick("drain_wb");
    set_idle();
    check("halt_set", 64'(pif.halt), 64'd1);
    check("halt_no_timeout", 64'(pif.halt_timeout), 64'd0);
    tick("halted");
    do_reset("rst_in_halted");
    check("rst_halted_halt", 64'(pif.halt), 64'd0);
`ifdef STALL_COUNTERS_EN
    check("rst_halted_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    // Drain timeout with three injected data-wait cycles.
    set_idle(); pif.halt_id = 1; tick("to_enter");
    for (int i = 0; i < 12; i++) begin
      set_idle();
      if (i == 2 || i == 3 || i == 5) begin pif.exmem_dreq = 1; pif.dhit = 0; end
      tick("to_drain");
      if (i == 9)  check("to_not_yet", 64'(pif.halt), 64'd0);
      if (i == 10) begin
        check("to_halt", 64'(pif.halt), 64'd1);
        check("to_flag", 64'(pif.halt_timeout), 64'd1);
      end
    end
    do_reset("rst_after_to");

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 49) == 0) || (m_state == 2 && $urandom_range(0, 3) == 0);
      pif.ihit       = ($urandom_range(0, 3) != 0);
      pif.dhit       = ($urandom_range(0, 2) != 0);
      pif.exmem_dreq = $urandom_range(0, 1);
      pif.idex_dREN  = $urandom_range(0, 1);
      pif.idex_wsel  = 5'($urandom_range(0, 3));
      pif.ifid_rs    = 5'($urandom_range(0, 3));
      pif.ifid_rt    = 5'($urandom_range(0, 3));
      pif.branch_ex  = ($urandom_range(0, 7) == 0);
      pif.jump_id    = ($urandom_range(0, 7) == 0);
      pif.halt_id    = ($urandom_range(0, 15) == 0);
      pif.halt_wb    = ($urandom_range(0, 9) == 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
